csa_mult_sequencer: RTL and testbench
=====================================

# csa_mult_sequencer

Iterative unsigned multiplier controller for the Wallace-tree datapath. It time-shares one row of 3:2 compressors (full adders built from half-adder pairs) across the partial products of an N×N multiply, accumulating them in carry-save form. It then time-shares one row of half adders to resolve the carry-save pair into the final 2N-bit product. It sits beside the combinational Wallace tree as the low-area alternative, behind a start/done handshake.

## Interface
- `WIDTH`, default 8: operand width N; product is 2N bits.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request a multiply; sampled only in IDLE.
- `a` input, WIDTH bits: multiplicand, captured when start is accepted.
- `b` input, WIDTH bits: multiplier, captured when start is accepted.
- `busy` output, 1 bit: high whenever state ≠ IDLE.
- `done` output, 1 bit: one-cycle pulse, high only in state DONE.
- `product` output, 2·WIDTH bits: result; valid from the done cycle and held until the next done.

## Operation
- Registers:
  - `S` and `C`: 2N-bit sum/carry words.
  - `A_r`, `B_r`: captured operands.
  - `i`: step counter, ⌈log2(N)⌉+1 bits.
  - `state`.
- States and transitions:
  - IDLE → ACCUM on start. Capture a and b; S=0, C=0, i=0.
  - ACCUM, every cycle: pp = B_r[i] ? (A_r << i) : 0, zero-extended to 2N bits.
    - S ← S ^ C ^ pp
    - C ← majority(S, C, pp) << 1, truncated to 2N bits
    - i ← i+1
    - After the i=N−1 update, go to RESOLVE.
  - RESOLVE, every cycle:
    - If C == 0: product ← S, go to DONE; S and C unchanged.
    - Else: S ← S ^ C, C ← (S & C) << 1, truncated to 2N bits; stay in RESOLVE.
  - DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - All sums are mod 2^(2N). Truncation is exact because the true product is below 2^(2N).
  - RESOLVE performs k updates, 0 ≤ k ≤ 2N. This bound is guaranteed because the carry gains at least one trailing zero per update.
- Boundary conditions:
  - start while busy, including in the DONE cycle: ignored. Operands are not recaptured.
  - a or b changing after acceptance: no effect.
  - b=0 or a=0: every pp is 0, so C stays 0 and k=0.
  - rst asserted in any state: immediately go to IDLE; S, C, i, product clear to 0; busy=0; done=0. No partial result appears.
- Reset values: busy=0, done=0, product=0, state=IDLE.

## Timing
- Let the edge that samples start high in IDLE be E0.
  - ACCUM occupies edges E1..EN.
  - RESOLVE occupies edges EN+1..EN+k+1.
  - done is high in the cycle following edge EN+k+1.
- Latency from the start edge to done high is N+k+2 cycles:
  - minimum N+2
  - maximum 3N+2
- busy rises the cycle after E0. It falls in the same cycle done falls, i.e. one cycle after the done pulse.
- The earliest next start is sampled in the first IDLE cycle after done, so back-to-back throughput is N+k+3 cycles.
- product updates only at the edge entering DONE and is stable during done.

## Structure
Shared package `wallace_pkg`:
- state enum: IDLE, ACCUM, RESOLVE, DONE
- default WIDTH constant
- a function returning 2·WIDTH

Natural sub-module `csa_row`:
- WIDTH-parameterised 3:2 compressor row, built from two half adders plus an OR per bit.
- Outputs: sum word, unshifted carry word.
- The RESOLVE half-adder row is a generate loop of the existing half adder.
- Control (FSM, counter, registers) lives in `csa_mult_sequencer`.

## Test plan
- WIDTH=8, a=0, b=0, start one cycle → done exactly 10 cycles after the start edge, product=0, k=0.
- a=3, b=5 → product=15; done within 8+k+2 cycles, with the bench checking k ≤ 16.
- a=255, b=255 → product=65025. Then a=255, b=1 → product=255. Second start issued the cycle after done falls.
- Mid-operation start: start with a=7, b=9; pulse start with a=2, b=2 during ACCUM and again in the DONE cycle → product=63, exactly one done pulse.
- Reset mid-operation: rst asserted in ACCUM step 4 → busy, done, product all 0 asynchronously. Then a=12, b=11 → product=132.
- Random sweep: 1000 random (a, b) pairs at WIDTH=8 and WIDTH=4 → product == a·b, latency in [N+2, 3N+2], done exactly one cycle wide.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared types and constants for the Wallace-tree multiplier family.
// Pure declarations: no logic, no latency, no flow control.
package wallace_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/csa_mult_sequencer_csa_row.sv
// Half adder cell and a row of 3:2 compressors built from half-adder pairs.
// Purely combinational, zero latency, no flow control.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

module csa_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [WIDTH-1:0] z_i,
    output logic [WIDTH-1:0] sum_o,
    output logic [WIDTH-1:0] carry_o
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;

    // Two half adders chained per bit; OR of their carries is the majority.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        half_adder u_ha0 (
            .a_i     (x_i[g]),
            .b_i     (y_i[g]),
            .sum_o   (s1[g]),
            .carry_o (c1[g])
        );
        half_adder u_ha1 (
            .a_i     (s1[g]),
            .b_i     (z_i[g]),
            .sum_o   (sum_o[g]),
            .carry_o (c2[g])
        );
    end

    assign carry_o = c1 | c2;

endmodule

// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned multiplier: N carry-save accumulate steps, then half-adder carry resolve.
// Latency N+k+2 cycles (k resolve steps, 0..2N); start is ignored while busy.
module csa_mult_sequencer
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = prod_width(WIDTH);
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [IW-1:0] LAST_STEP = IW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     s_q, s_d;
    logic [PW-1:0]     c_q, c_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     i_q, i_d;
    logic [PW-1:0]     product_q, product_d;

    logic              b_bit;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     csa_sum;
    logic [PW-1:0]     csa_carry;
    logic [PW-1:0]     ha_sum;
    logic [PW-1:0]     ha_carry;

    assign b_bit = |(b_q & (WIDTH'(1) << i_q));
    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign pp    = b_bit ? (a_ext << i_q) : '0;

    csa_row #(
        .WIDTH (PW)
    ) u_csa (
        .x_i     (s_q),
        .y_i     (c_q),
        .z_i     (pp),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    // Resolve row: plain half adders, ripple happens over successive cycles.
    for (genvar g = 0; g < PW; g++) begin : g_resolve
        half_adder u_ha (
            .a_i     (s_q[g]),
            .b_i     (c_q[g]),
            .sum_o   (ha_sum[g]),
            .carry_o (ha_carry[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = '0;
                    c_d     = '0;
                    i_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                s_d = csa_sum;
                c_d = csa_carry << 1;
                i_d = i_q + IW'(1);
                if (i_q == LAST_STEP) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (c_q == '0) begin
                    product_d = s_q;
                    state_d   = DONE;
                end else begin
                    s_d = ha_sum;
                    c_d = ha_carry << 1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer at WIDTH=8 and WIDTH=4: vector table, corner sequences, random sweep.
module tb_csa_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        start8, start4;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic        busy8, done8, busy4, done4;
    logic [15:0] prod8;
    logic [7:0]  prod4;

    csa_mult_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    csa_mult_sequencer #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w;
        int a;
        int b;
        int prod;
    } vec_t;

    typedef struct {
        longint prod;
        int     k;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   sel_w = 8;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (w=%0d): got %0d, expected %0d at %0t", nm, sel_w, act, exp, $time);
        end
    endtask

    function automatic logic cur_done();
        return (sel_w == 8) ? done8 : done4;
    endfunction

    function automatic logic cur_busy();
        return (sel_w == 8) ? busy8 : busy4;
    endfunction

    function automatic longint cur_prod();
        return (sel_w == 8) ? longint'(prod8) : longint'(prod4);
    endfunction

    task automatic drive(input logic s, input int av, input int bv);
        if (sel_w == 8) begin
            start8 = s; a8 = 8'(av); b8 = 8'(bv);
        end else begin
            start4 = s; a4 = 4'(av); b4 = 4'(bv);
        end
    endtask

    // Word-level reference of the carry-save algorithm; returns resolve step count k.
    function automatic int model_k(input int w, input int av, input int bv);
        longint mask, s, c, pp, ns;
        int k;
        mask = (longint'(1) << (2 * w)) - 1;
        s = 0; c = 0; k = 0;
        for (int i = 0; i < w; i++) begin
            pp = ((bv >> i) & 1) != 0 ? ((longint'(av) << i) & mask) : 0;
            ns = (s ^ c ^ pp) & mask;
            c  = (((s & c) | (s & pp) | (c & pp)) << 1) & mask;
            s  = ns;
        end
        while (c != 0 && k < 64) begin
            ns = s ^ c;
            c  = ((s & c) << 1) & mask;
            s  = ns;
            k++;
        end
        return k;
    endfunction

    // Issues one multiply and checks result, latency and handshake; leaves the DUT in IDLE.
    task automatic run_op(input int w, input int av, input int bv, input longint exp_prod,
                          output int lat);
        int   cnt;
        bit   seen;
        exp_t e;
        sel_w = w;
        @(negedge clk);
        drive(1'b1, av, bv);
        @(posedge clk);
        #1;
        drive(1'b0, $urandom, $urandom);
        check("busy_rise", cur_busy(), 1);
        e.prod = exp_prod;
        e.k    = model_k(w, av, bv);
        sb.push_back(e);
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 3 * w + 8) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cur_done()) seen = 1;
        end
        check("done_seen", seen, 1);
        lat = -1;
        if (seen) begin
            // Done is first visible to a synchronous consumer at the following edge.
            lat = cnt + 1;
            e = sb.pop_front();
            check("product", cur_prod(), e.prod);
            check("latency", lat, w + e.k + 2);
            check("k_bound", (e.k <= 2 * w), 1);
            check("lat_range", (lat >= w + 2 && lat <= 3 * w + 2), 1);
            check("busy_in_done", cur_busy(), 1);
            @(posedge clk);
            #1;
            check("done_width", cur_done(), 0);
            check("busy_fall", cur_busy(), 0);
            check("prod_hold", cur_prod(), e.prod);
        end else begin
            sb.delete();
        end
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int cnt;
        int extra;
        bit seen;
        exp_t e;

        vecs[0] = '{8, 0, 0, 0};
        vecs[1] = '{8, 3, 5, 15};
        vecs[2] = '{8, 255, 255, 65025};
        vecs[3] = '{8, 255, 1, 255};
        vecs[4] = '{8, 128, 2, 256};
        vecs[5] = '{8, 0, 77, 0};
        vecs[6] = '{4, 15, 15, 225};
        vecs[7] = '{4, 9, 0, 0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #3;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_prod8", prod8, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_prod4", prod4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].w, vecs[v].a, vecs[v].b, vecs[v].prod, lat);
            if (v == 0) check("zero_latency", lat, 10);
        end

        // Extra starts during ACCUM and in the DONE cycle must be ignored.
        sel_w = 8;
        @(negedge clk);
        drive(1'b1, 7, 9);
        @(posedge clk);
        #1;
        drive(1'b0, 7, 9);
        e.prod = 63;
        e.k    = model_k(8, 7, 9);
        sb.push_back(e);
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 2) drive(1'b1, 2, 2);
            if (cnt == 3) drive(1'b0, 2, 2);
            if (done8) seen = 1;
        end
        check("mid_done_seen", seen, 1);
        e = sb.pop_front();
        check("mid_product", prod8, e.prod);
        check("mid_latency", cnt + 1, 8 + e.k + 2);
        drive(1'b1, 2, 2);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0);
        check("mid_done_width", done8, 0);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) extra++;
        end
        check("mid_no_restart", extra, 0);
        check("mid_prod_hold", prod8, 63);

        // Asynchronous reset during ACCUM step 4 clears everything without a partial result.
        @(negedge clk);
        drive(1'b1, 200, 100);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_prod", prod8, 0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_still_idle", busy8, 0);
        run_op(8, 12, 11, 132, lat);

        for (int n = 0; n < 1000; n++) begin
            int av, bv;
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
            run_op(8, av, bv, longint'(av * bv), lat);
        end
        for (int n = 0; n < 1000; n++) begin
            int av, bv;
            av = $urandom_range(0, 15);
            bv = $urandom_range(0, 15);
            run_op(4, av, bv, longint'(av * bv), lat);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d of %0d checks failed", n_err, n_cmp);
        $fatal(1);
    end

endmodule
